// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared types and constants for the MM:SS time display driver:
//   - conversion FSM state type
//   - 7-segment glyphs, segment order {g,f,e,d,c,b,a}, active-high
//   - scan slot indices and their one-hot digit enables
//   - field/digit widths and the double-dabble nibble adjust helpers
// No ports (package).
// -----------------------------------------------------------------------------
package display_pkg;

    localparam int FIELD_W = 6;
    localparam int DIGITS  = 4;

    // Six shift iterations per conversion, counted 0..5.
    localparam logic [2:0] ITER_LAST = 3'd5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [6:0] SEG_0   = 7'b0111111;
    localparam logic [6:0] SEG_1   = 7'b0000110;
    localparam logic [6:0] SEG_2   = 7'b1011011;
    localparam logic [6:0] SEG_3   = 7'b1001111;
    localparam logic [6:0] SEG_4   = 7'b1100110;
    localparam logic [6:0] SEG_5   = 7'b1101101;
    localparam logic [6:0] SEG_6   = 7'b1111101;
    localparam logic [6:0] SEG_7   = 7'b0000111;
    localparam logic [6:0] SEG_8   = 7'b1111111;
    localparam logic [6:0] SEG_9   = 7'b1101111;
    localparam logic [6:0] SEG_OFF = 7'b0000000;

    // Scan slot indices; slot 0 is the rightmost digit.
    localparam logic [1:0] IDX_S_ONES = 2'd0;
    localparam logic [1:0] IDX_S_TENS = 2'd1;
    localparam logic [1:0] IDX_M_ONES = 2'd2;
    localparam logic [1:0] IDX_M_TENS = 2'd3;

    localparam logic [DIGITS-1:0] EN_S_ONES = 4'b0001;
    localparam logic [DIGITS-1:0] EN_S_TENS = 4'b0010;
    localparam logic [DIGITS-1:0] EN_M_ONES = 4'b0100;
    localparam logic [DIGITS-1:0] EN_M_TENS = 4'b1000;
    localparam logic [DIGITS-1:0] EN_NONE   = 4'b0000;

    // Double-dabble correction: a nibble of 5 or more would overflow past 9
    // when doubled, so bias it by 3 before the shift.
    function automatic logic [3:0] add3(input logic [3:0] nib);
        if (nib >= 4'd5) begin
            return nib + 4'd3;
        end else begin
            return nib;
        end
    endfunction

    // Apply the correction to both nibbles of a two-digit BCD register.
    function automatic logic [7:0] dabble_adjust(input logic [7:0] bcd);
        return {add3(bcd[7:4]), add3(bcd[3:0])};
    endfunction

endpackage

// File: rtl/time_display_driver_if.sv
// -----------------------------------------------------------------------------
// time_display_driver_if
// Bundles the time word, blank control and display/status outputs.
//   master : the time source / board side (drives time_in, blank)
//   slave  : the display driver (drives seg, dp, digit_en, bcd_out, busy)
// Signals:
//   time_in  [11:0] {minutes[5:0], seconds[5:0]}, unsigned binary
//   blank           forces display dark
//   seg      [6:0]  {g,f,e,d,c,b,a}, active-high
//   dp              decimal point / colon, active-high
//   digit_en [3:0]  one-hot digit select, bit0 = seconds ones
//   bcd_out  [15:0] {m_tens, m_ones, s_tens, s_ones}
//   busy            conversion in progress
// -----------------------------------------------------------------------------
interface time_display_driver_if;
    import display_pkg::*;

    logic [2*FIELD_W-1:0] time_in;
    logic                 blank;
    logic [6:0]           seg;
    logic                 dp;
    logic [DIGITS-1:0]    digit_en;
    logic [4*DIGITS-1:0]  bcd_out;
    logic                 busy;

    modport master (
        output time_in,
        output blank,
        input  seg,
        input  dp,
        input  digit_en,
        input  bcd_out,
        input  busy
    );

    modport slave (
        input  time_in,
        input  blank,
        output seg,
        output dp,
        output digit_en,
        output bcd_out,
        output busy
    );

endinterface

// File: rtl/time_display_driver_bcd_to_7seg.sv
// -----------------------------------------------------------------------------
// bcd_to_7seg
// Combinational BCD nibble to 7-segment glyph decoder.
//   nibble  [3:0] BCD digit; values above 9 decode to all segments off
//   pattern [6:0] {g,f,e,d,c,b,a}, active-high
// -----------------------------------------------------------------------------
module bcd_to_7seg
    import display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);

    // Glyph lookup; non-decimal nibbles are dark rather than garbage.
    always_comb begin
        pattern = SEG_OFF;
        case (nibble)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/time_display_driver.sv
// -----------------------------------------------------------------------------
// time_display_driver
// Converts the packed {minutes, seconds} time word to four BCD digits with a
// sequential shift-and-add-3 engine and drives a 4-digit multiplexed
// common-cathode 7-segment display (MM.SS, dp lit on the minutes-ones digit).
// Parameters:
//   SCAN_DIV  clk cycles per digit scan slot (>= 2)
// Ports:
//   clk   system clock
//   nrst  asynchronous active-low reset
//   bus   time_display_driver_if.slave (time_in, blank in; seg, dp,
//         digit_en, bcd_out, busy out)
// -----------------------------------------------------------------------------
module time_display_driver
    import display_pkg::*;
#(
    parameter int SCAN_DIV = 1000
) (
    input  logic                  clk,
    input  logic                  nrst,
    time_display_driver_if.slave  bus
);

    localparam int PRE_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

    // Conversion state
    state_t                 state_r;
    logic [2*FIELD_W-1:0]   captured_r;
    logic                   pending_r;
    logic [2:0]             iter_r;
    logic [FIELD_W-1:0]     min_bin_r;
    logic [FIELD_W-1:0]     sec_bin_r;
    logic [7:0]             min_bcd_r;
    logic [7:0]             sec_bcd_r;
    logic [4*DIGITS-1:0]    bcd_out_r;
    logic                   busy_r;

    // Scan state and registered display outputs
    logic [PRE_W-1:0]       prescale_r;
    logic [1:0]             scan_idx_r;
    logic [DIGITS-1:0]      digit_en_r;
    logic [6:0]             seg_r;
    logic                   dp_r;

    // Combinational helpers
    logic [7:0]             min_adj_s;
    logic [7:0]             sec_adj_s;
    logic [7:0]             min_bcd_nxt_s;
    logic [7:0]             sec_bcd_nxt_s;
    logic [FIELD_W-1:0]     min_bin_nxt_s;
    logic [FIELD_W-1:0]     sec_bin_nxt_s;
    logic [3:0]             digit_sel_s;
    logic [DIGITS-1:0]      digit_en_s;
    logic [6:0]             glyph_s;

    // One double-dabble step for both fields: adjust nibbles, then shift
    // {bcd, bin} left by one (bit 7 of the adjusted BCD is always zero for
    // inputs below 100, so dropping it loses nothing).
    always_comb begin
        min_adj_s = dabble_adjust(min_bcd_r);
        sec_adj_s = dabble_adjust(sec_bcd_r);
        {min_bcd_nxt_s, min_bin_nxt_s} = {min_adj_s[6:0], min_bin_r, 1'b0};
        {sec_bcd_nxt_s, sec_bin_nxt_s} = {sec_adj_s[6:0], sec_bin_r, 1'b0};
    end

    // Conversion FSM: capture a new time word, run six shift steps, commit.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r    <= IDLE;
            captured_r <= 12'd0;
            pending_r  <= 1'b1;
            iter_r     <= 3'd0;
            min_bin_r  <= 6'd0;
            sec_bin_r  <= 6'd0;
            min_bcd_r  <= 8'd0;
            sec_bcd_r  <= 8'd0;
            bcd_out_r  <= 16'h0000;
            busy_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    // pending forces one conversion after reset even if the
                    // input already equals the reset value of captured.
                    if (pending_r || (bus.time_in != captured_r)) begin
                        captured_r <= bus.time_in;
                        min_bin_r  <= bus.time_in[2*FIELD_W-1:FIELD_W];
                        sec_bin_r  <= bus.time_in[FIELD_W-1:0];
                        min_bcd_r  <= 8'd0;
                        sec_bcd_r  <= 8'd0;
                        iter_r     <= 3'd0;
                        pending_r  <= 1'b0;
                        busy_r     <= 1'b1;
                        state_r    <= SHIFT;
                    end else begin
                        state_r    <= IDLE;
                    end
                end
                SHIFT: begin
                    min_bcd_r <= min_bcd_nxt_s;
                    min_bin_r <= min_bin_nxt_s;
                    sec_bcd_r <= sec_bcd_nxt_s;
                    sec_bin_r <= sec_bin_nxt_s;
                    iter_r    <= iter_r + 3'd1;
                    if (iter_r == ITER_LAST) begin
                        state_r <= COMMIT;
                    end else begin
                        state_r <= SHIFT;
                    end
                end
                COMMIT: begin
                    // Only complete conversions ever reach bcd_out.
                    bcd_out_r <= {min_bcd_r, sec_bcd_r};
                    busy_r    <= 1'b0;
                    state_r   <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Scan prescaler and digit index; free-running, unaffected by blank.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            prescale_r <= '0;
            scan_idx_r <= 2'd0;
        end else begin
            if (prescale_r == PRE_LAST) begin
                prescale_r <= '0;
                scan_idx_r <= scan_idx_r + 2'd1;
            end else begin
                prescale_r <= prescale_r + PRE_W'(1);
                scan_idx_r <= scan_idx_r;
            end
        end
    end

    // Select the committed digit and one-hot enable for the current slot.
    always_comb begin
        digit_sel_s = 4'd0;
        digit_en_s  = EN_NONE;
        case (scan_idx_r)
            IDX_S_ONES: begin
                digit_sel_s = bcd_out_r[3:0];
                digit_en_s  = EN_S_ONES;
            end
            IDX_S_TENS: begin
                digit_sel_s = bcd_out_r[7:4];
                digit_en_s  = EN_S_TENS;
            end
            IDX_M_ONES: begin
                digit_sel_s = bcd_out_r[11:8];
                digit_en_s  = EN_M_ONES;
            end
            IDX_M_TENS: begin
                digit_sel_s = bcd_out_r[15:12];
                digit_en_s  = EN_M_TENS;
            end
            default: begin
                digit_sel_s = 4'd0;
                digit_en_s  = EN_NONE;
            end
        endcase
    end

    bcd_to_7seg u_bcd_to_7seg (
        .nibble  (digit_sel_s),
        .pattern (glyph_s)
    );

    // Register enable, glyph and dp together so they always agree.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            digit_en_r <= EN_S_ONES;
            seg_r      <= SEG_0;
            dp_r       <= 1'b0;
        end else begin
            if (bus.blank) begin
                digit_en_r <= EN_NONE;
                seg_r      <= SEG_OFF;
                dp_r       <= 1'b0;
            end else begin
                digit_en_r <= digit_en_s;
                seg_r      <= glyph_s;
                dp_r       <= (scan_idx_r == IDX_M_ONES);
            end
        end
    end

    assign bus.seg      = seg_r;
    assign bus.dp       = dp_r;
    assign bus.digit_en = digit_en_r;
    assign bus.bcd_out  = bcd_out_r;
    assign bus.busy     = busy_r;

endmodule
